// File: rtl/ula_seq_16_bits.sv
// ula_seq_16_bits
//   Sequential 16-bit ALU that performs ADD, SUB, EQ and INC by driving an
//   external 8-bit ALU (ula_8_bits) twice: once for the low byte (LO state)
//   and once for the high byte (HI state), chaining the carry between the
//   passes. A request is taken in IDLE, the result is presented in DONE and
//   held there until the consumer accepts it.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   req_valid / req_ready request handshake; op, a, b sampled on acceptance
//   op                    00 ADD, 01 SUB, 10 EQ, 11 INC
//   rsp_valid / rsp_ready response handshake
//   f, c_out, overflow    16-bit result, final carry, signed overflow
//   a_eq_b                16-bit equality of the latched operands
//   busy                  high whenever the block is not IDLE
//   ula_a, ula_b, ula_s,
//   ula_m, ula_c_in       drive to the external 8-bit ALU
//   ula_f, ula_c_out,
//   ula_a_eq_b            results from the external 8-bit ALU

module ula_seq_16_bits (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] f,
    output logic        c_out,
    output logic        overflow,
    output logic        a_eq_b,
    output logic        busy,
    output logic [7:0]  ula_a,
    output logic [7:0]  ula_b,
    output logic [3:0]  ula_s,
    output logic        ula_m,
    output logic        ula_c_in,
    input  logic [7:0]  ula_f,
    input  logic        ula_c_out,
    input  logic        ula_a_eq_b
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LO   = 2'b01,
        HI   = 2'b10,
        DONE = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_EQ  = 2'b10,
        OP_INC = 2'b11
    } op_t;

    localparam logic [3:0] S_ADD = 4'b0101;
    localparam logic [3:0] S_EQ  = 4'b1000;

    state_t      state;
    state_t      state_next;
    op_t         op_r;
    logic [15:0] a_r;
    logic [15:0] b_r;
    logic        carry_lo;
    logic        eq_lo;
    logic        armed;
    logic        accept;
    logic [7:0]  a_byte;
    logic [7:0]  b_byte;

    // armed stays low during reset and rises on the first edge after release,
    // so req_ready is 0 while in reset and comes up one edge later.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of block order.
        if (!rst_n) armed <= 1'b0;
        else        armed <= 1'b1;
    end

    assign req_ready = armed && (state == IDLE);
    assign rsp_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign accept    = req_valid && req_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic
    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch
        // is inferred.
        state_next = state;
        case (state)
            IDLE: if (accept)    state_next = LO;
            LO:                  state_next = HI;
            HI:                  state_next = DONE;
            DONE: if (rsp_ready) state_next = IDLE;
            default:             state_next = IDLE;
        endcase
    end

    // Operand byte for the current pass
    assign a_byte = (state == HI) ? a_r[15:8] : a_r[7:0];
    assign b_byte = (state == HI) ? b_r[15:8] : b_r[7:0];

    // Drive to the external 8-bit ALU. Outside LO/HI the ALU sees a quiet
    // logic-mode, all-zero pattern.
    always_comb begin
        ula_a    = 8'h00;
        ula_b    = 8'h00;
        ula_s    = 4'b0000;
        ula_m    = 1'b1;
        ula_c_in = 1'b0;
        if (state == LO || state == HI) begin
            ula_a = a_byte;
            ula_m = 1'b0;
            case (op_r)
                OP_ADD: begin
                    ula_s    = S_ADD;
                    ula_b    = b_byte;
                    ula_c_in = (state == LO) ? 1'b0 : carry_lo;
                end
                OP_SUB: begin
                    // A + ~B + 1: two's-complement subtraction
                    ula_s    = S_ADD;
                    ula_b    = ~b_byte;
                    ula_c_in = (state == LO) ? 1'b1 : carry_lo;
                end
                OP_INC: begin
                    ula_s    = S_ADD;
                    ula_b    = 8'h00;
                    ula_c_in = (state == LO) ? 1'b1 : carry_lo;
                end
                default: begin // OP_EQ
                    ula_s    = S_EQ;
                    ula_b    = b_byte;
                    ula_c_in = 1'b0;
                end
            endcase
        end
    end

    // Operand capture and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r     <= OP_ADD;
            a_r      <= 16'h0000;
            b_r      <= 16'h0000;
            carry_lo <= 1'b0;
            eq_lo    <= 1'b0;
            f        <= 16'h0000;
            c_out    <= 1'b0;
            overflow <= 1'b0;
            a_eq_b   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_r <= op_t'(op);
                        a_r  <= a;
                        b_r  <= b;
                    end
                end
                LO: begin
                    f[7:0]   <= (op_r == OP_EQ) ? 8'h00 : ula_f;
                    carry_lo <= ula_c_out;
                    eq_lo    <= ula_a_eq_b;
                end
                HI: begin
                    f[15:8] <= (op_r == OP_EQ) ? 8'h00 : ula_f;
                    if (op_r == OP_EQ) begin
                        c_out    <= 1'b0;
                        overflow <= 1'b0;
                        a_eq_b   <= eq_lo && ula_a_eq_b;
                    end else begin
                        c_out    <= ula_c_out;
                        // ula_b[7] is the sign of the operand actually fed
                        // (~B for SUB, 0 for INC); ula_f[7] is the result sign.
                        overflow <= (a_r[15] == ula_b[7]) && (ula_f[7] != a_r[15]);
                        a_eq_b   <= (a_r == b_r);
                    end
                end
                default: ; // DONE: results hold until accepted
            endcase
        end
    end

endmodule

// File: tb/tb_ula_seq_16_bits.sv
// tb_ula_seq_16_bits
//   Bench for ula_seq_16_bits paired with a behavioural ula_8_bits model
//   (s=0101/m=0: A+B+cin; s=1000: equality). Stimulus pushes the expected
//   response into a queue; a monitor pops and compares on each response
//   handshake. Directed checks cover reset, latency, carry chaining, hold
//   under back-pressure and reset in the middle of an operation.

module tb_ula_seq_16_bits;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] f;
    logic        c_out;
    logic        overflow;
    logic        a_eq_b;
    logic        busy;
    logic [7:0]  ula_a;
    logic [7:0]  ula_b;
    logic [3:0]  ula_s;
    logic        ula_m;
    logic        ula_c_in;
    logic [7:0]  ula_f;
    logic        ula_c_out;
    logic        ula_a_eq_b;

    typedef struct packed {
        logic [15:0] f;
        logic        c;
        logic        v;
        logic        eq;
    } rsp_t;

    rsp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    ula_seq_16_bits dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .op         (op),
        .a          (a),
        .b          (b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .f          (f),
        .c_out      (c_out),
        .overflow   (overflow),
        .a_eq_b     (a_eq_b),
        .busy       (busy),
        .ula_a      (ula_a),
        .ula_b      (ula_b),
        .ula_s      (ula_s),
        .ula_m      (ula_m),
        .ula_c_in   (ula_c_in),
        .ula_f      (ula_f),
        .ula_c_out  (ula_c_out),
        .ula_a_eq_b (ula_a_eq_b)
    );

    // Behavioural 8-bit ALU
    always_comb begin
        logic [8:0] sum;
        sum        = {1'b0, ula_a} + {1'b0, ula_b} + {8'h00, ula_c_in};
        ula_f      = 8'h00;
        ula_c_out  = 1'b0;
        ula_a_eq_b = (ula_a == ula_b);
        if (!ula_m && ula_s == 4'b0101) begin
            ula_f     = sum[7:0];
            ula_c_out = sum[8];
        end else if (!ula_m && ula_s == 4'b1000) begin
            ula_f = ~(ula_a ^ ula_b);
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Response monitor: compares on every handshake, independent of stimulus
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_rsp: got f=%h expected no response", f);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                check("rsp_f",        32'(f),        32'(e.f));
                check("rsp_c_out",    32'(c_out),    32'(e.c));
                check("rsp_overflow", 32'(overflow), 32'(e.v));
                check("rsp_a_eq_b",   32'(a_eq_b),   32'(e.eq));
            end
        end
    end

    // Wait (bounded) for req_ready, sampled 1 time unit after a rising edge
    task automatic wait_ready(output bit ok);
        int w;
        w = 0;
        while (!req_ready && w < 20) begin
            @(posedge clk);
            #1;
            w++;
        end
        ok = req_ready;
        if (!ok) check("req_ready_wait", 32'(req_ready), 32'd1);
    endtask

    // Issue one operation, check latency and the HI-pass carry-in, hold the
    // response for hold_cycles with rsp_ready low, then accept it.
    task automatic issue(input string name, input logic [1:0] o,
                         input logic [15:0] va, input logic [15:0] vb,
                         input logic [15:0] ef, input logic ec, input logic ev,
                         input logic eeq, input logic hi_cin, input int hold_cycles);
        bit    ok;
        int    edges;
        rsp_t  e;
        wait_ready(ok);
        if (!ok) return;
        req_valid = 1'b1;
        op = o;
        a  = va;
        b  = vb;
        e.f = ef; e.c = ec; e.v = ev; e.eq = eeq;
        exp_q.push_back(e);
        @(posedge clk);            // acceptance edge (edge 1)
        #1;
        req_valid = 1'b0;
        edges = 1;
        check({name, "_busy_lo"}, 32'(busy), 32'd1);
        while (edges < 10) begin
            @(posedge clk);
            #1;
            edges++;
            if (edges == 2) begin
                check({name, "_hi_cin"},   32'(ula_c_in),  32'(hi_cin));
                check({name, "_ready_hi"}, 32'(req_ready), 32'd0);
            end
            if (rsp_valid) break;
        end
        check({name, "_latency"}, 32'(edges), 32'd3);
        // Back-pressure: requests presented in DONE must be ignored
        for (int i = 0; i < hold_cycles; i++) begin
            req_valid = 1'b1;
            @(posedge clk);
            #1;
            check({name, "_hold_valid"}, 32'(rsp_valid), 32'd1);
            check({name, "_hold_f"},     32'(f),         32'(ef));
            check({name, "_hold_ready"}, 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check({name, "_released"}, 32'(rsp_valid), 32'd0);
        check({name, "_idle_m"},   32'(ula_m),     32'd1);
    endtask

    initial begin
        bit ok;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        op        = 2'b00;
        a         = 16'h0000;
        b         = 16'h0000;

        // Reset state
        #12;
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy",  32'(busy),      32'd0);
        check("rst_f",     32'(f),         32'd0);
        check("rst_ula_m", 32'(ula_m),     32'd1);
        check("rst_ula_s", 32'(ula_s),     32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_ready_before_edge", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        check("post_rst_ready_after_edge", 32'(req_ready), 32'd1);

        //     name        op     a         b         f         c     v     eq    hicin hold
        issue("add_carry", 2'b00, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        issue("add_ovf",   2'b00, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1, 0);
        issue("add_wrap",  2'b00, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 0);
        issue("add_same",  2'b00, 16'h1234, 16'h1234, 16'h2468, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        issue("sub_neg",   2'b01, 16'h0005, 16'h000A, 16'hFFFB, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        issue("sub_ovf",   2'b01, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        issue("eq_true",   2'b10, 16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        issue("eq_false",  2'b10, 16'h1234, 16'h1334, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        issue("inc_hold",  2'b11, 16'h00FF, 16'h0000, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b1, 5);

        // Reset while in HI: operation discarded, no response
        wait_ready(ok);
        if (ok) begin
            req_valid = 1'b1;
            op = 2'b00;
            a  = 16'hAAAA;
            b  = 16'h5555;
            @(posedge clk);    // accepted -> LO
            #1;
            req_valid = 1'b0;
            @(posedge clk);    // -> HI
            #1;
            check("mid_rst_in_hi", 32'(busy), 32'd1);
            rst_n = 1'b0;
            #1;
            check("mid_rst_busy",  32'(busy),      32'd0);
            check("mid_rst_valid", 32'(rsp_valid), 32'd0);
            check("mid_rst_ready", 32'(req_ready), 32'd0);
            check("mid_rst_f",     32'(f),         32'd0);
            check("mid_rst_ula_m", 32'(ula_m),     32'd1);
            check("mid_rst_ula_a", 32'(ula_a),     32'd0);
            repeat (2) @(posedge clk);
            #1;
            check("mid_rst_no_rsp", 32'(rsp_valid), 32'd0);
            @(negedge clk);
            rst_n = 1'b1;
            @(posedge clk);
            #1;
            check("mid_rst_ready_after", 32'(req_ready), 32'd1);
            check("mid_rst_no_pending",  32'(exp_q.size()), 32'd0);
        end

        issue("add_after_rst", 2'b00, 16'h0001, 16'h0002, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0, 0);

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ula_seq_16_bits.md
ULA_SEQ_16_BITS -- requirements
Module: ula_seq_16_bits

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk and rst_n.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- op  in  2  operation: 00 ADD, 01 SUB, 10 EQ, 11 INC.
- a  in  16  operand A.
- b  in  16  operand B; ignored for INC.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- f  out  16  result.
- c_out  out  1  final carry.
- overflow  out  1  signed overflow.
- a_eq_b  out  1  A equals B.
- busy  out  1  high whenever state is not IDLE.
- ula_a, ula_b  out  8  operand bytes to the external ula_8_bits.
- ula_s  out  4  function select to the ALU.
- ula_m  out  1  mode to the ALU.
- ula_c_in  out  1  carry-in to the ALU.
- ula_f  in  8  ALU result.
- ula_c_out  in  1  ALU carry-out.
- ula_a_eq_b  in  1  ALU equality flag.

Function
REQ-003 States SHALL be IDLE, LO, HI and DONE.
- IDLE: req_ready=1.
- LO and HI: one ALU pass each.
- DONE: rsp_valid=1.
REQ-004 On req_valid&&req_ready at a clk edge, the block SHALL latch a, b and op, and move IDLE->LO.
REQ-005 LO->HI and HI->DONE SHALL each take exactly one cycle, so rsp_valid rises on the 3rd edge after acceptance.
REQ-006 DONE->IDLE SHALL occur on the edge where rsp_ready=1; with rsp_ready=0, DONE and all result outputs SHALL hold indefinitely.
REQ-007 req_ready SHALL be 0 outside IDLE; req_valid outside IDLE SHALL be ignored; no request is accepted in the DONE->IDLE cycle.
REQ-008 In LO the block SHALL drive the low bytes (bits 7:0) on ula_a/ula_b; in HI it SHALL drive the high bytes (15:8).
REQ-009 ADD SHALL drive ula_m=0, ula_s=0101, ula_b=B byte; ula_c_in=0 in LO and the registered LO ula_c_out in HI.
REQ-010 SUB SHALL drive ula_m=0, ula_s=0101, ula_b=~B byte; ula_c_in=1 in LO and the registered LO carry in HI.
REQ-011 INC SHALL drive ula_m=0, ula_s=0101, ula_b=00; ula_c_in=1 in LO and the registered LO carry in HI.
REQ-012 EQ SHALL drive ula_m=0, ula_s=1000, ula_c_in=0 in both passes; f, c_out and overflow SHALL be 0 in the response.
REQ-013 At the end of LO the block SHALL register ula_f into f[7:0], plus the carry and the equality flag.
REQ-014 At the end of HI the block SHALL register:
- ula_f into f[15:8];
- c_out = HI ula_c_out;
- a_eq_b = LO flag AND HI flag.
REQ-015 overflow SHALL be (A[15]==Bfed[15]) && (f[15]!=A[15]), where Bfed is the byte actually driven (~B for SUB, 0 for INC); it is 0 for EQ.
REQ-016 For ADD/SUB/INC, a_eq_b SHALL still report 16-bit equality of the latched A and B, computed by the block itself.
REQ-017 In IDLE and DONE, ula_a, ula_b, ula_s and ula_c_in SHALL be 0 and ula_m SHALL be 1.
REQ-018 For SUB, c_out=1 SHALL mean no borrow (A>=B unsigned).

Reset
REQ-019 rst_n=0 SHALL, asynchronously, force:
- state to IDLE;
- rsp_valid=0, busy=0, req_ready=0, f=0000, c_out=0, overflow=0, a_eq_b=0;
- ALU drive outputs to the REQ-017 values.
REQ-020 req_ready SHALL rise on the first clk edge after rst_n deasserts.
REQ-021 Reset mid-operation (LO, HI or DONE) SHALL discard the operation with no response.

Verification
REQ-022 The bench SHALL pair ula_seq_16_bits with ula_8_bits and cover these scenarios:
- ADD 00FF+0001 -> f=0100, c_out=0, overflow=0; HI pass shows ula_c_in=1.
- ADD 7FFF+0001 -> f=8000, overflow=1, c_out=0; ADD FFFF+0001 -> f=0000, c_out=1, overflow=0.
- SUB 0005-000A -> f=FFFB, c_out=0, overflow=0; SUB 8000-0001 -> f=7FFF, c_out=1, overflow=1.
- EQ 1234 vs 1234 -> a_eq_b=1; EQ 1234 vs 1334 -> a_eq_b=0 (differs in high byte only).
- INC 00FF -> f=0100; rsp_valid exactly 3 edges after acceptance; rsp_ready held 0 for 5 cycles -> f and state hold, req_ready=0.
- rst_n pulsed low while in HI -> immediate IDLE outputs, no rsp_valid; next ADD 0001+0002 -> f=0003.
